// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the EX stage: holds HI/LO, models fixed op latency, requests ID stalls.
// Optional: define MDU_MADD_EN to make md_op 3'b111 a signed multiply-accumulate into {hi,lo}.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        id_md_use,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [63:0]     result, result_nxt;
    logic            commit, commit_nxt;
    logic [31:0]     hi_nxt, lo_nxt;

    logic [63:0]        prod_s, prod_u;
    logic [31:0]        divisor, q_u, r_u;
    logic signed [31:0] q_s, r_s;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // A zero divisor is replaced by 1 so the dividers never yield X; the result is discarded anyway.
    assign divisor = (rt_val == 32'd0) ? 32'd1 : rt_val;
    assign q_u     = rs_val / divisor;
    assign r_u     = rs_val % divisor;

    always_comb begin
        q_s = 32'sd0;
        r_s = 32'sd0;
        if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
            q_s = 32'sh8000_0000;
            r_s = 32'sd0;
        end else begin
            q_s = $signed(rs_val) / $signed(divisor);
            r_s = $signed(rs_val) % $signed(divisor);
        end
    end

`ifdef MDU_MADD_EN
    logic [63:0] madd_sum;
    assign madd_sum = {hi, lo} + prod_s;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            result <= '0;
            commit <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            result <= result_nxt;
            commit <= commit_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        result_nxt = result;
        commit_nxt = commit;
        hi_nxt     = hi;
        lo_nxt     = lo;
        case (state)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        3'b001: begin
                            result_nxt = prod_s;
                            commit_nxt = 1'b1;
                            count_nxt  = CW'(MULT_CYCLES);
                            state_nxt  = RUN;
                        end
                        3'b010: begin
                            result_nxt = prod_u;
                            commit_nxt = 1'b1;
                            count_nxt  = CW'(MULT_CYCLES);
                            state_nxt  = RUN;
                        end
                        3'b011: begin
                            result_nxt = {r_s, q_s};
                            commit_nxt = (rt_val != 32'd0);
                            count_nxt  = CW'(DIV_CYCLES);
                            state_nxt  = RUN;
                        end
                        3'b100: begin
                            result_nxt = {r_u, q_u};
                            commit_nxt = (rt_val != 32'd0);
                            count_nxt  = CW'(DIV_CYCLES);
                            state_nxt  = RUN;
                        end
                        3'b101: hi_nxt = rs_val;
                        3'b110: lo_nxt = rs_val;
`ifdef MDU_MADD_EN
                        3'b111: begin
                            result_nxt = madd_sum;
                            commit_nxt = 1'b1;
                            count_nxt  = CW'(MULT_CYCLES);
                            state_nxt  = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                count_nxt = count - CW'(1);
                if (count == CW'(1)) begin
                    state_nxt = IDLE;
                    if (commit) begin
                        hi_nxt = result[63:32];
                        lo_nxt = result[31:0];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == RUN);
    assign stall_req = id_md_use & (busy | (start & (md_op >= 3'b001) & (md_op <= 3'b100)));

endmodule
